// File: rtl/eth_rx_stream_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_PORTS AXI-Stream sources
// onto one registered output slice feeding the ethernet parser. Whole frames
// are granted and held until tlast; every output beat carries its source port.
module eth_rx_stream_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic [31:0]                     frame_count
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Registered state
    state_t                 state_q,      state_d;
    logic [IDX_W-1:0]       grant_q,      grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]  m_data_q,     m_data_d;
    logic [KEEP_WIDTH-1:0]  m_keep_q,     m_keep_d;
    logic                   m_valid_q,    m_valid_d;
    logic                   m_last_q,     m_last_d;
    logic [ID_WIDTH-1:0]    m_tid_q,      m_tid_d;
    logic [31:0]            frame_count_q, frame_count_d;

    // Arbitration / handshake helpers
    logic                   rr_found;
    logic [IDX_W-1:0]       rr_pick;
    logic [IDX_W-1:0]       scan_idx;
    logic                   out_room;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic                   sel_last;

    // Round-robin scan starting one past the last port that finished a frame
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_q;
        scan_idx = last_grant_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            scan_idx = IDX_W'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!rr_found && s_axis_tvalid[scan_idx]) begin
                rr_found = 1'b1;
                rr_pick  = scan_idx;
            end
        end
    end

    // Ready goes only to the granted port, and only when the output slice can take a beat
    always_comb begin
        out_room      = !m_valid_q || m_axis_tready;
        s_axis_tready = '0;
        if (state_q == XFER) begin
            s_axis_tready[grant_q] = out_room;
        end
        sel_data = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        sel_keep = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last = s_axis_tlast[grant_q];
        accept   = (state_q == XFER) && s_axis_tvalid[grant_q] && out_room;
    end

    // Next-state for the FSM, the output slice and the frame counter
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        m_data_d      = m_data_q;
        m_keep_d      = m_keep_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        m_tid_d       = m_tid_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                // The grant decision costs one bubble cycle per frame.
                if (enable && rr_found) begin
                    grant_d = rr_pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Only tlast releases the grant; enable is ignored mid-frame.
                if (accept && sel_last) begin
                    last_grant_d  = grant_q;
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output slice drains in either state; a new beat only loads in XFER.
        if (accept) begin
            m_data_d  = sel_data;
            m_keep_d  = sel_keep;
            m_last_d  = sel_last;
            m_tid_d   = ID_WIDTH'(grant_q);
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    // Single register bank; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            m_data_q      <= '0;
            m_keep_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            m_tid_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            m_data_q      <= m_data_d;
            m_keep_q      <= m_keep_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            m_tid_q       <= m_tid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = (state_q == XFER);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_eth_rx_stream_arbiter.sv
// Directed bench for eth_rx_stream_arbiter: per-port source queues, an output
// capture list, and hand-derived expectations for order, timing and counters.
module tb_eth_rx_stream_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [NP*DW-1:0]   s_axis_tdata;
    logic [NP*KW-1:0]   s_axis_tkeep;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP-1:0]      s_axis_tlast;
    logic [NP-1:0]      s_axis_tready;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic [IW-1:0]      m_axis_tid;
    logic               m_axis_tready;
    logic               busy;
    logic [31:0]        frame_count;

    eth_rx_stream_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tready(m_axis_tready),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t          srcq[NP][$];
    logic [DW-1:0]  cap_d[$];
    logic [KW-1:0]  cap_k[$];
    logic           cap_l[$];
    logic [IW-1:0]  cap_t[$];
    int             cap_c[$];

    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    logic           tready_toggle = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int port, input int fr, input int b);
        logic [15:0] bb;
        bb = 16'(b);
        return {8'hA5, 8'(port), 16'(fr), 16'hBEEF ^ (bb * 16'h0111), bb};
    endfunction

    task automatic push_frame(input int port, input int fr, input int n, input logic [KW-1:0] lastkeep);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = mk_data(port, fr, i);
            b.keep = (i == n - 1) ? lastkeep : 8'hFF;
            b.last = (i == n - 1);
            srcq[port].push_back(b);
        end
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_t.delete(); cap_c.delete();
    endtask

    task automatic wait_beats(input int n, input int maxc);
        int k;
        k = 0;
        while (cap_d.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check_val("beat_wait", 64'(cap_d.size() >= n), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int port, input int fr,
                               input int n, input logic [KW-1:0] lastkeep);
        for (int b = 0; b < n; b++) begin
            if (base + b >= cap_d.size()) begin
                check_val({tag, "_missing"}, 64'(cap_d.size()), 64'(base + n));
                return;
            end
            check_val({tag, "_data"}, cap_d[base+b], mk_data(port, fr, b));
            check_val({tag, "_keep"}, 64'(cap_k[base+b]), 64'((b == n - 1) ? lastkeep : 8'hFF));
            check_val({tag, "_last"}, 64'(cap_l[base+b]), 64'(b == n - 1));
            check_val({tag, "_tid"},  64'(cap_t[base+b]), 64'(port));
        end
    endtask

    // Source/sink model: drives sources at negedge, samples handshakes just before posedge
    initial begin : bfm
        beat_t         hb;
        logic [NP-1:0] s_fire;
        logic          hold_pend;
        logic [DW-1:0] h_d;
        logic [KW-1:0] h_k;
        logic          h_l;
        logic [IW-1:0] h_t;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        hold_pend     = 1'b0;
        h_d = '0; h_k = '0; h_l = 1'b0; h_t = '0;
        forever begin
            @(negedge clk);
            m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
            for (int i = 0; i < NP; i++) begin
                if (srcq[i].size() > 0) begin
                    hb = srcq[i][0];
                    s_axis_tvalid[i]          = 1'b1;
                    s_axis_tdata[i*DW +: DW]  = hb.data;
                    s_axis_tkeep[i*KW +: KW]  = hb.keep;
                    s_axis_tlast[i]           = hb.last;
                end else begin
                    s_axis_tvalid[i]          = 1'b0;
                    s_axis_tdata[i*DW +: DW]  = '0;
                    s_axis_tkeep[i*KW +: KW]  = '0;
                    s_axis_tlast[i]           = 1'b0;
                end
            end
            #3;
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                check_val("ready_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
                if (hold_pend) begin
                    check_val("hold_valid", 64'(m_axis_tvalid), 64'd1);
                    check_val("hold_data",  m_axis_tdata, h_d);
                    check_val("hold_keep",  64'(m_axis_tkeep), 64'(h_k));
                    check_val("hold_last",  64'(m_axis_tlast), 64'(h_l));
                    check_val("hold_tid",   64'(m_axis_tid), 64'(h_t));
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    check_val("src_stall", 64'(s_axis_tready), 64'd0);
                end
                hold_pend = m_axis_tvalid && !m_axis_tready;
                h_d = m_axis_tdata; h_k = m_axis_tkeep; h_l = m_axis_tlast; h_t = m_axis_tid;
                s_fire = s_axis_tvalid & s_axis_tready;
                for (int i = 0; i < NP; i++) begin
                    if (s_fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    cap_d.push_back(m_axis_tdata);
                    cap_k.push_back(m_axis_tkeep);
                    cap_l.push_back(m_axis_tlast);
                    cap_t.push_back(m_axis_tid);
                    cap_c.push_back(cyc);
                end
            end
            @(posedge clk);
            cyc++;
        end
    end

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NP; i++) srcq[i].delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        clear_caps();
    endtask

    initial begin : main
        int k;
        rst    = 1'b1;
        enable = 1'b1;

        // 1: reset state, then a 6-beat frame from port 0
        repeat (4) @(negedge clk);
        #2;
        check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("rst_tready", 64'(s_axis_tready), 64'd0);
        check_val("rst_busy",   64'(busy), 64'd0);
        check_val("rst_fcount", 64'(frame_count), 64'd0);
        check_val("rst_tdata",  m_axis_tdata, 64'd0);
        rst = 1'b0;
        clear_caps();
        push_frame(0, 1, 6, 8'h0F);
        wait_beats(6, 60);
        check_frame("t1", 0, 0, 1, 6, 8'h0F);
        check_val("t1_fcount", 64'(frame_count), 64'd1);

        // 2: all four ports request from reset; order 0,1,2,3 with one idle cycle between frames
        apply_reset(2);
        for (int p = 0; p < NP; p++) push_frame(p, 20 + p, 2, 8'hFF);
        wait_beats(8, 100);
        for (int p = 0; p < NP; p++) begin
            check_frame("t2", 2 * p, p, 20 + p, 2, 8'hFF);
            if (cap_c.size() >= 2 * p + 2) check_val("t2_contig", 64'(cap_c[2*p+1] - cap_c[2*p]), 64'd1);
            if (p > 0 && cap_c.size() >= 2 * p + 1) check_val("t2_gap", 64'(cap_c[2*p] - cap_c[2*p-1]), 64'd2);
        end
        check_val("t2_fcount", 64'(frame_count), 64'd4);

        // 3: output backpressure toggling during a 6-beat frame
        clear_caps();
        tready_toggle = 1'b1;
        push_frame(1, 30, 6, 8'h3F);
        wait_beats(6, 100);
        repeat (6) @(negedge clk);
        tready_toggle = 1'b0;
        check_val("t3_count", 64'(cap_d.size()), 64'd6);
        check_frame("t3", 0, 1, 30, 6, 8'h3F);
        check_val("t3_fcount", 64'(frame_count), 64'd5);

        // 4: enable dropped mid-frame on port 2 while port 3 waits
        repeat (3) @(negedge clk);
        clear_caps();
        push_frame(2, 40, 4, 8'h01);
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("t4_busy_up", 64'(busy), 64'd1);
        enable = 1'b0;
        push_frame(3, 41, 3, 8'h07);
        wait_beats(4, 60);
        repeat (4) @(negedge clk);
        #3;
        check_val("t4_busy_down", 64'(busy), 64'd0);
        check_val("t4_p3_waiting", 64'(srcq[3].size()), 64'd3);
        check_val("t4_no_ready", 64'(s_axis_tready), 64'd0);
        check_val("t4_count_held", 64'(cap_d.size()), 64'd4);
        enable = 1'b1;
        wait_beats(7, 60);
        check_frame("t4a", 0, 2, 40, 4, 8'h01);
        check_frame("t4b", 4, 3, 41, 3, 8'h07);
        check_val("t4_fcount", 64'(frame_count), 64'd7);

        // 5: reset mid-frame; port 0 has priority afterwards
        repeat (3) @(negedge clk);
        push_frame(0, 50, 2, 8'hFF);
        wait_beats(2, 40);
        repeat (3) @(negedge clk);
        clear_caps();
        push_frame(1, 55, 6, 8'hFF);
        wait_beats(2, 40);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("t5_tlast",  64'(m_axis_tlast), 64'd0);
        check_val("t5_tdata",  m_axis_tdata, 64'd0);
        check_val("t5_tkeep",  64'(m_axis_tkeep), 64'd0);
        check_val("t5_tid",    64'(m_axis_tid), 64'd0);
        check_val("t5_busy",   64'(busy), 64'd0);
        check_val("t5_fcount", 64'(frame_count), 64'd0);
        check_val("t5_tready", 64'(s_axis_tready), 64'd0);
        for (int i = 0; i < NP; i++) srcq[i].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_caps();
        push_frame(1, 52, 2, 8'hFF);
        push_frame(0, 51, 2, 8'hFF);
        wait_beats(4, 60);
        check_frame("t5a", 0, 0, 51, 2, 8'hFF);
        check_frame("t5b", 2, 1, 52, 2, 8'hFF);
        check_val("t5_fcount2", 64'(frame_count), 64'd2);

        // 6: frame counter wraps
        repeat (3) @(negedge clk);
        force dut.frame_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        check_val("t6_preload", 64'(frame_count), 64'hFFFF_FFFF);
        clear_caps();
        push_frame(2, 60, 2, 8'hFF);
        wait_beats(2, 40);
        check_frame("t6", 0, 2, 60, 2, 8'hFF);
        check_val("t6_wrap", 64'(frame_count), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
